bcd_display_mux: RTL
====================

Name: bcd_display_mux

Overview:
- Downstream stage of the BCD multiplier.
- Latches the two-digit BCD result (tens, units) and time-multiplexes it onto a two-digit common-cathode 7-segment display.
- A programmable refresh counter drives the multiplexing.
- Flags invalid BCD input, so multiplier faults are visible on the board.

Parameters:
- REFRESH_DIV, 1000, clock cycles each digit stays enabled before the scan moves to the other digit. Legal range 1..65535.
- CNT_W, 16, width of the refresh counter. Must satisfy 2^CNT_W >= REFRESH_DIV.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  when high at a clock edge, capture bcd_tens/bcd_units.
- bcd_tens  input  4  tens digit from the multiplier (bcd_1).
- bcd_units  input  4  units digit from the multiplier (bcd_2).
- seg  output  7  segment drive {g,f,e,d,c,b,a}, active-high.
- an  output  2  digit enable, one-hot, active-high; an[0] = units, an[1] = tens.
- err  output  1  high while the held value contains a digit > 9.

Behaviour:
- Reset (asynchronous, active-high; effective immediately, independent of clk):
  - tens_q = 0, units_q = 0, sel = 0 (units), refresh count = 0, err = 0.
  - Therefore an = 2'b01 and seg = 7'b0111111 ("0") while rst is high and until the first scan toggle.
- Load:
  - load = 1 at an edge → tens_q/units_q take the inputs.
  - New digits are visible on seg from the following cycle (one-cycle latency).
  - load = 0 → digits held indefinitely.
- err:
  - Registered on load: err = (bcd_tens > 9) | (bcd_units > 9).
  - Cleared only by a load of a valid pair, or by rst.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1, then wraps to 0 and toggles sel on the same edge.
  - REFRESH_DIV = 1 → sel toggles every cycle.
  - Counter free-runs; load does not reset it.
- Simultaneous load and wrap: both take effect on the same edge. The new sel shows the newly loaded digit for that position.
- an = (sel == 0) ? 2'b01 : 2'b10. Never 2'b00 or 2'b11 outside the optional feature.
- seg is a combinational decode of the selected held digit:

  | Digit | seg       |
  |-------|-----------|
  | 0     | 0111111   |
  | 1     | 0000110   |
  | 2     | 1011011   |
  | 3     | 1001111   |
  | 4     | 1100110   |
  | 5     | 1101101   |
  | 6     | 1111101   |
  | 7     | 0000111   |
  | 8     | 1111111   |
  | 9     | 1101111   |
  | 10–15 | 1000000   |

  Digits 10–15 show a dash (segment g only).
- Reset asserted mid-scan: all state returns to reset values immediately; scanning restarts on units with count 0 after rst deasserts.

Optional Feature:
- Macro: BCD_DISPLAY_BLANK_EN.
- Defined: when sel = 1 and tens_q == 0, seg = 7'b0000000 (leading-zero blank). an still = 2'b10, so scan timing is unchanged. Units digit is never blanked.
- Undefined: tens digit 0 is displayed as "0".

Test Plan:
- Reset, REFRESH_DIV = 4: assert rst mid-cycle → seg = 0111111, an = 01, err = 0 with no clock edge; after release, an toggles to 10 on the 4th rising edge, then back to 01 four edges later.
- Load tens = 8, units = 1 (9*9 = 81): during an = 10 expect seg = 1111111; during an = 01 expect seg = 0000110; err = 0; value held after load drops.
- Load tens = 0, units = 7: tens slot shows 0111111 without BCD_DISPLAY_BLANK_EN; with it defined, tens slot shows 0000000 (an = 10) and units slot shows 0000111.
- Load tens = 12, units = 3: err = 1 the cycle after the load edge; tens slot = 1000000. Then load tens = 2, units = 4 → err = 0 the next cycle; tens slot = 1011011.
- REFRESH_DIV = 1, load asserted on a wrap edge with tens = 5, units = 6: sel becomes 1 and seg = 1101101 on the very next cycle; an alternates every cycle.
- Sweep all 100 pairs i*j for i, j in 0..9, loaded from the multiplier: each digit slot decodes per the table, and err stays 0 throughout.

Source files
------------

// File: rtl/bcd_display_mux.sv
// Latches a two-digit BCD result and time-multiplexes it onto a two-digit
// common-cathode 7-segment display. Define BCD_DISPLAY_BLANK_EN to blank a leading zero.
`timescale 1ns/1ps
module bcd_display_mux #(
  parameter int REFRESH_DIV = 1000,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] bcd_tens,
  input  logic [3:0] bcd_units,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [3:0]       tens_q, tens_d;
  logic [3:0]       units_q, units_d;
  logic             err_q, err_d;
  logic             sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       digit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tens_q  <= 4'd0;
      units_q <= 4'd0;
      err_q   <= 1'b0;
      sel_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
      err_q   <= err_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  // Load and scan are independent, so a load on a wrap edge lands together
  // with the new selection and the new digit shows immediately.
  always_comb begin
    tens_d  = tens_q;
    units_d = units_q;
    err_d   = err_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q + CNT_W'(1);
    if (load) begin
      tens_d  = bcd_tens;
      units_d = bcd_units;
      err_d   = (bcd_tens > 4'd9) | (bcd_units > 4'd9);
    end
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      sel_d = ~sel_q;
    end
  end

  assign digit = sel_q ? tens_q : units_q;
  assign an    = sel_q ? 2'b10 : 2'b01;
  assign err   = err_q;

  always_comb begin
    seg = 7'b1000000;
    case (digit)
      4'd0: seg = 7'b0111111;
      4'd1: seg = 7'b0000110;
      4'd2: seg = 7'b1011011;
      4'd3: seg = 7'b1001111;
      4'd4: seg = 7'b1100110;
      4'd5: seg = 7'b1101101;
      4'd6: seg = 7'b1111101;
      4'd7: seg = 7'b0000111;
      4'd8: seg = 7'b1111111;
      4'd9: seg = 7'b1101111;
      default: seg = 7'b1000000;
    endcase
`ifdef BCD_DISPLAY_BLANK_EN
    if (sel_q && (tens_q == 4'd0)) seg = 7'b0000000;
`else
`endif
  end

endmodule
